// File: rtl/q2_bus_pkg.sv
// Shared definitions for open-drain bus arbiters:
// state encoding, counter sizing, pull-up settle time.
package q2_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RELEASE = 2'd2
  } bus_state_e;

  // Board-level pull-up network and clock, in ohms / pF / ps.
  localparam int PULLUP_OHMS   = 2200;
  localparam int BUS_CAP_PF    = 50;
  localparam int CLK_PERIOD_PS = 100000;

  // 10-90% rise of an RC edge is about 2.2 RC; ohm * pF = ps.
  localparam int RISE_PS =
    (PULLUP_OHMS * BUS_CAP_PF * 22) / 10;

  localparam int DEFAULT_SETTLE_CYCLES =
    (RISE_PS + CLK_PERIOD_PS - 1) / CLK_PERIOD_PS;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/od_bus_arbiter_rr_select.sv
// Combinational round-robin picker: first set request
// at or above ptr, wrapping around.
module rr_select #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx
);

  always_comb begin : pick
    int j;
    j      = 0;
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        onehot[j] = 1'b1;
        idx       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/od_bus_arbiter.sv
// Round-robin owner arbiter for an open-drain bus, with a
// max hold time and an undriven settle window per handover.
module od_bus_arbiter
  import q2_bus_pkg::*;
#(
  parameter int REQUESTERS    = 4,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int HOLD_MAX      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQUESTERS-1:0] req,
  output logic [REQUESTERS-1:0] grant,
  output logic                  busy,
  output logic                  settling,
  output logic                  timeout
);

  localparam int PW = $clog2(REQUESTERS);
  localparam int HW = cnt_width(HOLD_MAX);
  localparam int SW = cnt_width(SETTLE_CYCLES);

  bus_state_e            state_q, state_d;
  logic [REQUESTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]         settle_cnt_q, settle_cnt_d;
  logic                  timeout_q, timeout_d;

  logic [REQUESTERS-1:0] excl;
  logic                  sel_valid;
  logic [REQUESTERS-1:0] sel_onehot;
  logic [PW-1:0]         sel_idx;
  logic                  owner_req;
  logic                  arb;
  logic                  leave;

  // With no settle window the outgoing owner must not win
  // the handover pick on the edge it releases.
  assign excl =
    (SETTLE_CYCLES == 0 && state_q == DRIVE) ? grant_q : '0;

  assign owner_req = |(req & grant_q);

  rr_select #(
    .N  (REQUESTERS),
    .PW (PW)
  ) u_rr_select (
    .req    (req & ~excl),
    .ptr    (rr_ptr_q),
    .valid  (sel_valid),
    .onehot (sel_onehot),
    .idx    (sel_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    hold_cnt_d   = hold_cnt_q;
    settle_cnt_d = settle_cnt_q;
    timeout_d    = 1'b0;
    arb          = 1'b0;
    leave        = 1'b0;

    unique case (state_q)
      IDLE: arb = 1'b1;
      DRIVE: begin
        hold_cnt_d = hold_cnt_q + HW'(1);
        if (!owner_req) begin
          leave = 1'b1;
        end else if (hold_cnt_q == HW'(HOLD_MAX - 1)) begin
          leave     = 1'b1;
          timeout_d = 1'b1;
        end
        if (leave) begin
          grant_d      = '0;
          settle_cnt_d = SW'(SETTLE_CYCLES);
          state_d      = RELEASE;
          if (SETTLE_CYCLES == 0) arb = 1'b1;
        end
      end
      RELEASE: begin
        if (settle_cnt_q == SW'(1)) arb = 1'b1;
        else settle_cnt_d = settle_cnt_q - SW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (arb) begin
      if (sel_valid) begin
        state_d    = DRIVE;
        grant_d    = sel_onehot;
        hold_cnt_d = '0;
        rr_ptr_d   = (sel_idx == PW'(REQUESTERS - 1)) ?
                     '0 : sel_idx + PW'(1);
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      hold_cnt_q   <= '0;
      settle_cnt_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);
  assign settling = (state_q == RELEASE);
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_od_bus_arbiter.sv
// Directed scoreboard bench for od_bus_arbiter, default
// settle window and a zero-settle instance.
module tb_od_bus_arbiter;

  typedef struct packed {
    logic [3:0] g;
    logic       b;
    logic       s;
    logic       t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_a = '0;
  logic [3:0] grant_a;
  logic       busy_a, settling_a, timeout_a;
  logic [3:0] req_z = '0;
  logic [3:0] grant_z;
  logic       busy_z, settling_z, timeout_z;

  int   checks = 0;
  int   errors = 0;
  logic inv_en = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  od_bus_arbiter #(
    .REQUESTERS    (4),
    .SETTLE_CYCLES (3),
    .HOLD_MAX      (16)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req_a),
    .grant    (grant_a),
    .busy     (busy_a),
    .settling (settling_a),
    .timeout  (timeout_a)
  );

  od_bus_arbiter #(
    .REQUESTERS    (4),
    .SETTLE_CYCLES (0),
    .HOLD_MAX      (16)
  ) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .req      (req_z),
    .grant    (grant_z),
    .busy     (busy_z),
    .settling (settling_z),
    .timeout  (timeout_z)
  );

  task automatic step(
    input logic r, input logic [3:0] rq,
    input logic [3:0] g, input logic b,
    input logic s, input logic t, input string tag
  );
    exp_t e;
    rst   = r;
    req_a = rq;
    sb_q.push_back('{g: g, b: b, s: s, t: t});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    assert ({grant_a, busy_a, settling_a, timeout_a} === e)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag,
             {grant_a, busy_a, settling_a, timeout_a}, e);
    end
  endtask

  task automatic step_z(
    input logic r, input logic [3:0] rq,
    input logic [3:0] g, input logic b,
    input logic s, input logic t, input string tag
  );
    exp_t e;
    rst   = r;
    req_z = rq;
    sb_q.push_back('{g: g, b: b, s: s, t: t});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    assert ({grant_z, busy_z, settling_z, timeout_z} === e)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag,
             {grant_z, busy_z, settling_z, timeout_z}, e);
    end
  endtask

  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      assert ($onehot0(grant_a) && !(settling_a && |grant_a)
              && $onehot0(grant_z) && !settling_z)
      else begin
        errors++;
        $error("FAIL invariant: observed=%b/%b/%b/%b expected=onehot0,no-overlap",
               grant_a, settling_a, grant_z, settling_z);
      end
    end
  end

  initial begin
    logic [3:0] g;
    int c;

    step(1, 4'b0000, 4'b0000, 0, 0, 0, "reset");
    inv_en = 1'b1;

    // single owner, normal release, settle, idle
    step(0, 4'b0001, 4'b0001, 1, 0, 0, "t1_grant");
    repeat (3) step(0, 4'b0001, 4'b0001, 1, 0, 0, "t1_hold");
    step(0, 4'b0000, 4'b0000, 1, 1, 0, "t1_release");
    repeat (2) step(0, 4'b0000, 4'b0000, 1, 1, 0, "t1_settle");
    step(0, 4'b0000, 4'b0000, 0, 0, 0, "t1_idle");

    // all request: rotation with forced releases
    step(1, 4'b0000, 4'b0000, 0, 0, 0, "t2_reset");
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 19; i++) begin
        g = (i < 16) ? 4'(1 << (k % 4)) : 4'b0000;
        step(0, 4'b1111, g, 1, i >= 16, i == 16, "t2_rotate");
      end
    end

    // lone requester keeps winning after each settle window
    step(1, 4'b0100, 4'b0000, 0, 0, 0, "t3_reset");
    for (int i = 0; i < 40; i++) begin
      c = i % 19;
      g = (c < 16) ? 4'b0100 : 4'b0000;
      step(0, 4'b0100, g, 1, c >= 16, c == 16, "t3_lone");
    end

    // reset mid-DRIVE, then priority restarts at master 0
    step(1, 4'b0100, 4'b0000, 0, 0, 0, "t6_rst_drive");
    step(0, 4'b1111, 4'b0001, 1, 0, 0, "t6_prio0");
    step(0, 4'b1111, 4'b0001, 1, 0, 0, "t6_hold");

    // pending request waits for owner release plus settle
    step(1, 4'b0000, 4'b0000, 0, 0, 0, "t4_reset");
    step(0, 4'b0010, 4'b0010, 1, 0, 0, "t4_m1_grant");
    repeat (2) step(0, 4'b1010, 4'b0010, 1, 0, 0, "t4_m3_pend");
    step(0, 4'b1000, 4'b0000, 1, 1, 0, "t4_m1_drop");
    repeat (2) step(0, 4'b1000, 4'b0000, 1, 1, 0, "t4_settle");
    step(0, 4'b1000, 4'b1000, 1, 0, 0, "t4_m3_grant");
    step(0, 4'b0000, 4'b0000, 1, 1, 0, "t4_m3_drop");
    repeat (2) step(0, 4'b0000, 4'b0000, 1, 1, 0, "t4_settle2");
    step(0, 4'b0000, 4'b0000, 0, 0, 0, "t4_idle");

    // zero settle window: direct handover
    step_z(1, 4'b0000, 4'b0000, 0, 0, 0, "t5_reset");
    step_z(0, 4'b0001, 4'b0001, 1, 0, 0, "t5_m0_grant");
    step_z(0, 4'b0011, 4'b0001, 1, 0, 0, "t5_m1_pend");
    step_z(0, 4'b0010, 4'b0010, 1, 0, 0, "t5_handover");
    step_z(0, 4'b0010, 4'b0010, 1, 0, 0, "t5_m1_hold");
    step_z(0, 4'b0000, 4'b0000, 0, 0, 0, "t5_idle");
    for (int i = 0; i < 16; i++)
      step_z(0, 4'b0100, 4'b0100, 1, 0, 0, "t5_lone");
    step_z(0, 4'b0100, 4'b0000, 0, 0, 1, "t5_timeout");
    step_z(0, 4'b0100, 4'b0100, 1, 0, 0, "t5_regrant");

    inv_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
